cpu_run_ctrl: RTL and testbench

Sequences execution of the single-cycle MIPS CPU on the board. Replaces free-running divided-clock stepping with a one-cycle clock-enable pulse (cpu_ce) at a switch-selected rate. Adds run/pause/single-step modes and halt handling: execution stops on a CPU halt (syscall) and resumes on Go. Sits between board switches/buttons and MIPS_CPU. It also exports a retired-cycle count for the 7-segment display mux.

---
 rtl/cpu_run_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/pause/single-step/halt sequencer for the MIPS CPU: issues one-clk cpu_ce
// pulses at a switch-selected rate and counts the pulses issued.
module cpu_run_ctrl #(
    parameter int unsigned DIV0 = 10000,
    parameter int unsigned DIV1 = 100000,
    parameter int unsigned DIV2 = 1000000,
    parameter int unsigned DIV3 = 10000000,
    parameter int          CW   = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [1:0]    hz,
    input  logic          run,
    input  logic          step,
    input  logic          go,
    input  logic          halt,
    output logic          cpu_ce,
    output logic          running,
    output logic          halted,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_PAUSE  = 3'd0,
        S_STEP   = 3'd1,
        S_RUN    = 3'd2,
        S_HALT   = 3'd3,
        S_RESUME = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_ce;
    logic          r_running;
    logic          r_halted;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_div;
    logic          r_run_m, r_run_s;
    logic          r_step_m, r_step_s, r_step_d, r_step_p;
    logic          r_go_m, r_go_s, r_go_d, r_go_p;
    logic [1:0]    r_hz, r_hz_d;
    logic [CW-1:0] w_n;
    logic          w_hz_chg;
    logic          w_tick;

    // Two-flop synchronizers for the board inputs plus registered rising-edge pulses.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_run_m  <= 1'b0;
            r_run_s  <= 1'b0;
            r_step_m <= 1'b0;
            r_step_s <= 1'b0;
            r_step_d <= 1'b0;
            r_step_p <= 1'b0;
            r_go_m   <= 1'b0;
            r_go_s   <= 1'b0;
            r_go_d   <= 1'b0;
            r_go_p   <= 1'b0;
            r_hz     <= 2'b00;
            r_hz_d   <= 2'b00;
        end else begin
            r_run_m  <= run;
            r_run_s  <= r_run_m;
            r_step_m <= step;
            r_step_s <= r_step_m;
            r_step_d <= r_step_s;
            r_step_p <= r_step_s & ~r_step_d;
            r_go_m   <= go;
            r_go_s   <= r_go_m;
            r_go_d   <= r_go_s;
            r_go_p   <= r_go_s & ~r_go_d;
            r_hz     <= hz;
            r_hz_d   <= r_hz;
        end
    end

    // Period selection from the captured rate switches.
    always_comb begin
        w_n = CW'(DIV0);
        case (r_hz)
            2'b00:   w_n = CW'(DIV0);
            2'b01:   w_n = CW'(DIV1);
            2'b10:   w_n = CW'(DIV2);
            2'b11:   w_n = CW'(DIV3);
            default: w_n = CW'(DIV0);
        endcase
    end

    // A rate change restarts the period instead of ticking against a stale count.
    assign w_hz_chg = (r_hz != r_hz_d);
    assign w_tick   = (r_state == S_RUN) && r_run_s && !w_hz_chg && (r_div == (w_n - CW'(1)));

    // Rate divider: only advances while running, restarts on every tick or rate change.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_div <= '0;
        end else if ((r_state != S_RUN) || !r_run_s || w_hz_chg || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + CW'(1);
        end
    end

    // Sequencing FSM with registered cpu_ce/running/halted.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= S_PAUSE;
            r_ce      <= 1'b0;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_ce <= 1'b0;
            case (r_state)
                S_PAUSE: begin
                    if (r_run_s) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end else if (r_step_p && halt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (r_step_p) begin
                        r_state <= S_STEP;
                        r_ce    <= 1'b1;
                    end else begin
                        r_state <= S_PAUSE;
                    end
                end
                S_STEP: begin
                    r_state <= S_PAUSE;
                end
                S_RUN: begin
                    if (!r_run_s) begin
                        r_state   <= S_PAUSE;
                        r_running <= 1'b0;
                    end else if (w_tick && halt) begin
                        r_state   <= S_HALT;
                        r_running <= 1'b0;
                        r_halted  <= 1'b1;
                    end else if (w_tick) begin
                        r_ce <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_HALT: begin
                    if (r_go_p) begin
                        r_state  <= S_RESUME;
                        r_halted <= 1'b0;
                        r_ce     <= 1'b1;
                    end else begin
                        r_state <= S_HALT;
                    end
                end
                S_RESUME: begin
                    if (r_run_s) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end else begin
                        r_state <= S_PAUSE;
                    end
                end
                default: begin
                    r_state   <= S_PAUSE;
                    r_running <= 1'b0;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    // Retired-cycle counter, saturating at all ones.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (r_ce && (r_cnt != {CW{1'b1}})) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign cpu_ce      = r_ce;
    assign running     = r_running;
    assign halted      = r_halted;
    assign cycle_count = r_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: small dividers (4/8/12/15), plus a 4-bit
// counter instance sharing the same stimulus to observe saturation.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [1:0]  hz;
    logic        run, step, go, halt;
    logic        cpu_ce, running, halted;
    logic [31:0] cycle_count;
    logic        s_cpu_ce, s_running, s_halted;
    logic [3:0]  s_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.DIV0(4), .DIV1(8), .DIV2(12), .DIV3(15), .CW(32)) dut (
        .clk(clk), .clr(clr), .hz(hz), .run(run), .step(step), .go(go), .halt(halt),
        .cpu_ce(cpu_ce), .running(running), .halted(halted), .cycle_count(cycle_count)
    );

    cpu_run_ctrl #(.DIV0(4), .DIV1(8), .DIV2(12), .DIV3(15), .CW(4)) dut_sat (
        .clk(clk), .clr(clr), .hz(hz), .run(run), .step(step), .go(go), .halt(halt),
        .cpu_ce(s_cpu_ce), .running(s_running), .halted(s_halted), .cycle_count(s_count)
    );

    task automatic test_reset;
        clr = 1'b1; run = 1'b0; step = 1'b0; go = 1'b0; halt = 1'b0; hz = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (cpu_ce !== 1'b0 || running !== 1'b0 || halted !== 1'b0 || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: ce=%b run=%b halt=%b cnt=%0d, want 0 0 0 0",
                     cpu_ce, running, halted, cycle_count);
        end
        checks++;
        if (s_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_sat_count: got %0d want 0", s_count);
        end
        clr = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (cpu_ce !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_pause: ce=%b running=%b want 0 0", cpu_ce, running);
        end
    endtask

    task automatic test_run;
        bit e;
        run = 1'b1;
        for (int i = 1; i <= 43; i++) begin
            @(negedge clk);
            e = (i >= 7) && (((i - 7) % 4) == 0);
            checks++;
            if (cpu_ce !== e) begin
                errors++;
                $display("FAIL run_ce[%0d]: got %b want %b", i, cpu_ce, e);
            end
            if (e) exp_cnt++;
        end
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL run_running: got %b want 1", running);
        end
        run = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (cpu_ce !== 1'b0) begin
                errors++;
                $display("FAIL run_stop_ce[%0d]: got %b want 0", i, cpu_ce);
            end
        end
        checks++;
        if (running !== 1'b0 || cycle_count !== 32'(exp_cnt) || exp_cnt != 10) begin
            errors++;
            $display("FAIL run_stop_state: running=%b cnt=%0d want running=0 cnt=10",
                     running, cycle_count);
        end
    endtask

    task automatic test_step;
        bit e;
        step = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            e = (i == 4);
            checks++;
            if (cpu_ce !== e) begin
                errors++;
                $display("FAIL step_ce[%0d]: got %b want %b", i, cpu_ce, e);
            end
            if (e) exp_cnt++;
        end
        checks++;
        if (cycle_count !== 32'd11 || running !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL step_state: cnt=%0d running=%b halted=%b want 11 0 0",
                     cycle_count, running, halted);
        end
        step = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_step_halt;
        bit e;
        halt = 1'b1;
        step = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if (cpu_ce !== 1'b0) begin
                errors++;
                $display("FAIL step_halt_ce[%0d]: got %b want 0", i, cpu_ce);
            end
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL step_halt_halted: got %b want 1", halted);
        end
        step = 1'b0;
        halt = 1'b0;
        repeat (4) @(negedge clk);
        go = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            e = (i == 4);
            checks++;
            if (cpu_ce !== e) begin
                errors++;
                $display("FAIL resume_pause_ce[%0d]: got %b want %b", i, cpu_ce, e);
            end
            if (e) exp_cnt++;
        end
        checks++;
        if (halted !== 1'b0 || running !== 1'b0 || cycle_count !== 32'd12) begin
            errors++;
            $display("FAIL resume_pause_state: halted=%b running=%b cnt=%0d want 0 0 12",
                     halted, running, cycle_count);
        end
        go = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bit e;
        step = 1'b1;
        @(negedge clk);
        run = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            e = (i == 8);
            checks++;
            if (cpu_ce !== e) begin
                errors++;
                $display("FAIL b2b_ce[%0d]: got %b want %b", i, cpu_ce, e);
            end
            if (i == 4) begin
                checks++;
                if (running !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_run_wins: running=%b want 1", running);
                end
            end
            if (e) exp_cnt++;
        end
        run = 1'b0;
        step = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (cpu_ce !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stop_ce[%0d]: got %b want 0", i, cpu_ce);
            end
        end
        checks++;
        if (cycle_count !== 32'd13 || running !== 1'b0) begin
            errors++;
            $display("FAIL b2b_state: cnt=%0d running=%b want 13 0", cycle_count, running);
        end
    endtask

    task automatic test_halt;
        bit e;
        run = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            e = (i == 7) || (i == 11);
            checks++;
            if (cpu_ce !== e) begin
                errors++;
                $display("FAIL halt_run_ce[%0d]: got %b want %b", i, cpu_ce, e);
            end
            if (e) exp_cnt++;
            if (i == 12) halt = 1'b1;
        end
        checks++;
        if (halted !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL halt_entered: halted=%b running=%b want 1 0", halted, running);
        end
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            checks++;
            if (cpu_ce !== 1'b0 || halted !== 1'b1) begin
                errors++;
                $display("FAIL halt_hold[%0d]: ce=%b halted=%b want 0 1", j, cpu_ce, halted);
            end
            if (j == 10) step = 1'b1;
            if (j == 20) step = 1'b0;
        end
        halt = 1'b0;
        go = 1'b1;
        step = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            e = (i == 4) || (i == 9) || (i == 13) || (i == 17);
            checks++;
            if (cpu_ce !== e) begin
                errors++;
                $display("FAIL go_ce[%0d]: got %b want %b", i, cpu_ce, e);
            end
            checks++;
            if (running !== (i >= 5) || halted !== (i <= 3)) begin
                errors++;
                $display("FAIL go_state[%0d]: running=%b halted=%b want %b %b",
                         i, running, halted, (i >= 5), (i <= 3));
            end
            if (e) exp_cnt++;
        end
        go = 1'b0;
        step = 1'b0;
    endtask

    task automatic test_rate;
        bit e;
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (cpu_ce === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rate_sync: no cpu_ce within 12 cycles, want one");
        end else begin
            exp_cnt++;
        end
        @(negedge clk);
        @(negedge clk);
        hz = 2'b01;
        for (int i = 3; i <= 28; i++) begin
            @(negedge clk);
            e = (i == 12) || (i == 20) || (i == 28);
            checks++;
            if (cpu_ce !== e) begin
                errors++;
                $display("FAIL rate_ce[%0d]: got %b want %b", i, cpu_ce, e);
            end
            if (e) exp_cnt++;
        end
    endtask

    task automatic test_clr;
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (cpu_ce === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL clr_sync: no cpu_ce within 20 cycles, want one");
        end
        checks++;
        if (cycle_count !== 32'(exp_cnt) || s_count !== 4'd15) begin
            errors++;
            $display("FAIL pre_clr_count: cnt=%0d sat=%0d want %0d 15", cycle_count, s_count, exp_cnt);
        end
        clr = 1'b1;
        run = 1'b0;
        hz = 2'b00;
        #1;
        checks++;
        if (cpu_ce !== 1'b0 || cycle_count !== 32'd0 || running !== 1'b0 || s_count !== 4'd0) begin
            errors++;
            $display("FAIL clr_async: ce=%b cnt=%0d running=%b sat=%0d want 0 0 0 0",
                     cpu_ce, cycle_count, running, s_count);
        end
        exp_cnt = 0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (running !== 1'b0 || cpu_ce !== 1'b0) begin
                errors++;
                $display("FAIL clr_pause[%0d]: running=%b ce=%b want 0 0", i, running, cpu_ce);
            end
        end
        run = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (running !== (i == 3)) begin
                errors++;
                $display("FAIL clr_rerun[%0d]: running=%b want %b", i, running, (i == 3));
            end
        end
        run = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (cpu_ce !== 1'b0) begin
                errors++;
                $display("FAIL clr_rerun_stop[%0d]: ce=%b want 0", i, cpu_ce);
            end
        end
    endtask

    task automatic test_saturate;
        bit e;
        logic [3:0] sat_exp;
        run = 1'b1;
        for (int i = 1; i <= 90; i++) begin
            @(negedge clk);
            sat_exp = (exp_cnt > 15) ? 4'd15 : 4'(exp_cnt);
            checks++;
            if (cycle_count !== 32'(exp_cnt) || s_count !== sat_exp) begin
                errors++;
                $display("FAIL sat_count[%0d]: cnt=%0d sat=%0d want %0d %0d",
                         i, cycle_count, s_count, exp_cnt, sat_exp);
            end
            e = (i >= 7) && (((i - 7) % 4) == 0);
            checks++;
            if (cpu_ce !== e) begin
                errors++;
                $display("FAIL sat_ce[%0d]: got %b want %b", i, cpu_ce, e);
            end
            if (e) exp_cnt++;
        end
        checks++;
        if (exp_cnt != 21 || s_count !== 4'd15 || cycle_count !== 32'd21) begin
            errors++;
            $display("FAIL sat_final: cnt=%0d sat=%0d want 21 15", cycle_count, s_count);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_step_halt();
        test_back_to_back();
        test_halt();
        test_rate();
        test_clr();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
